tc_to_sign_magnitude: RTL and testbench

Bit-serial converter from two's-complement to sign-magnitude. It is the decode direction paired with the team's 32-bit two's-complement negation path. It accepts one WIDTH-bit word over a valid/ready handshake and walks it LSB-first, one bit per clock, using the copy-until-first-one-then-invert rule. It then presents `out_sign` plus an unsigned `out_mag` over a second valid/ready handshake.

---
 rtl/tc_sm_pkg.sv | 17 +
 rtl/tc_serial_cell.sv | 35 +++
 rtl/tc_to_sign_magnitude.sv | 138 +++++++++++++
 tb/tb_tc_to_sign_magnitude.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_sm_pkg.sv
// Shared types and sizing helpers for the two's-complement to
// sign-magnitude serial converter.
package tc_sm_pkg;

   localparam int TC_SM_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   function automatic int tc_cnt_w(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/tc_serial_cell.sv
// One-bit conversion cell: copy bits until the first one has passed,
// then invert (negative operands only).
module tc_serial_cell (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   input  logic sign_i,
   input  logic bit_i,
   output logic bit_o
);

   logic seen_q;
   logic seen_d;

   always_comb begin
      seen_d = seen_q;
      if (clr_i) begin
         seen_d = 1'b0;
      end else if (en_i && sign_i) begin
         seen_d = seen_q | bit_i;
      end
   end

   assign bit_o = (sign_i && seen_q) ? ~bit_i : bit_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         seen_q <= 1'b0;
      end else begin
         seen_q <= seen_d;
      end
   end

endmodule

// File: rtl/tc_to_sign_magnitude.sv
// Bit-serial two's-complement to sign-magnitude converter.
// TC_SM_EARLY_DONE_EN: non-negative words skip the serial walk.
module tc_to_sign_magnitude
   import tc_sm_pkg::*;
#(
   parameter int WIDTH = TC_SM_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [WIDTH-1:0] out_mag,
   output logic             busy
);

   localparam int CW = tc_cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shr_q, shr_d;
   logic [WIDTH-1:0] mag_q, mag_d;
   logic             sign_q, sign_d;
   logic             osign_q, osign_d;
   logic             load;
   logic             shift_en;
   logic             out_bit;
`ifdef TC_SM_EARLY_DONE_EN
   logic             byp_q, byp_d;
`endif

   tc_serial_cell u_cell (
      .clk_i  (clk),
      .rst_ni (reset),
      .clr_i  (load),
      .en_i   (shift_en),
      .sign_i (sign_q),
      .bit_i  (shr_q[0]),
      .bit_o  (out_bit)
   );

   // The operand register doubles as the magnitude accumulator:
   // bits leave at the LSB while converted bits enter at the MSB.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shr_d    = shr_q;
      mag_d    = mag_q;
      sign_d   = sign_q;
      osign_d  = osign_q;
      load     = 1'b0;
      shift_en = 1'b0;
`ifdef TC_SM_EARLY_DONE_EN
      byp_d    = byp_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               load    = 1'b1;
               shr_d   = in_data;
               sign_d  = in_data[WIDTH-1];
               cnt_d   = '0;
               state_d = ST_SHIFT;
`ifdef TC_SM_EARLY_DONE_EN
               byp_d   = ~in_data[WIDTH-1];
`endif
            end
         end
         ST_SHIFT: begin
`ifdef TC_SM_EARLY_DONE_EN
            if (byp_q) begin
               mag_d   = shr_q;
               osign_d = 1'b0;
               byp_d   = 1'b0;
               state_d = ST_DONE;
            end else
`endif
            begin
               shift_en = 1'b1;
               shr_d    = {out_bit, shr_q[WIDTH-1:1]};
               cnt_d    = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  mag_d   = {out_bit, shr_q[WIDTH-1:1]};
                  osign_d = sign_q;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         shr_q   <= '0;
         mag_q   <= '0;
         sign_q  <= 1'b0;
         osign_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shr_q   <= shr_d;
         mag_q   <= mag_d;
         sign_q  <= sign_d;
         osign_q <= osign_d;
      end
   end

`ifdef TC_SM_EARLY_DONE_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byp_q <= 1'b0;
      end else begin
         byp_q <= byp_d;
      end
   end
`endif

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign out_sign  = osign_q;
   assign out_mag   = mag_q;

endmodule

// File: tb/tb_tc_to_sign_magnitude.sv
// Bench for tc_to_sign_magnitude: vector table, corner sequences,
// and random words against an arithmetic reference.
module tb_tc_to_sign_magnitude;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic         out_sign;
   logic [W-1:0] out_mag;
   logic         busy;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   tc_to_sign_magnitude #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sign  (out_sign),
      .out_mag   (out_mag),
      .busy      (busy)
   );

   typedef struct {
      logic         s;
      logic [W-1:0] m;
   } res_t;

   typedef struct {
      logic [W-1:0] d;
      logic         s;
      logic [W-1:0] m;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic res_t ref_model(input logic [W-1:0] x);
      res_t r;
      r.s = x[W-1];
      r.m = r.s ? (W'(0) - x) : x;
      return r;
   endfunction

   function automatic int exp_lat(input logic [W-1:0] d);
`ifdef TC_SM_EARLY_DONE_EN
      return d[W-1] ? W : 1;
`else
      return (d === d) ? W : W;
`endif
   endfunction

   // Scoreboard: every accepted word must come out once, in order
   res_t exp_q[$];
   res_t got_q[$];
   int   acc_cyc[$];
   int   cyc = 0;
   int   acc_n = 0;
   res_t sb_e;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         exp_q.delete();
      end else begin
         cyc++;
         if (out_valid) begin
            chk("sb_expected", exp_q.size() != 0, 1);
         end
         if (out_valid && out_ready && exp_q.size() != 0) begin
            sb_e = exp_q.pop_front();
            got_q.push_back('{out_sign, out_mag});
            chk("sb_sign", out_sign, sb_e.s);
            chk("sb_mag", out_mag, sb_e.m);
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_model(in_data));
            acc_cyc.push_back(cyc);
            acc_n++;
         end
      end
   end

   task automatic run_word(input logic [W-1:0] d, input int stall,
                           output logic s, output logic [W-1:0] m,
                           output int lat);
      int t;
      s = 1'b0;
      m = '0;
      lat = -1;
      @(negedge clk);
      in_valid = 1'b1;
      in_data = d;
      out_ready = 1'b0;
      t = 0;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_data = W'($urandom);
      chk("in_ready_low", in_ready, 0);
      chk("busy_high", busy, 1);
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (!out_valid) begin
         chk("result_timeout", 0, 1);
         return;
      end
      s = out_sign;
      m = out_mag;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("stall_sign", out_sign, s);
         chk("stall_mag", out_mag, m);
         chk("stall_valid", out_valid, 1);
         chk("stall_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("consumed", out_valid, 0);
      chk("idle_ready", in_ready, 1);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   vec_t         tbl[10];
   logic         s;
   logic [W-1:0] m;
   logic [W-1:0] d;
   int           lat;
   int           t;
   int           n0;
   int           g0;
   int           a1;
   int           a2;
   int           pulses;
   res_t         r;

   initial begin
      tbl[0] = '{32'hF000_0000, 1'b1, 32'h1000_0000};
      tbl[1] = '{32'h8000_0000, 1'b1, 32'h8000_0000};
      tbl[2] = '{32'hFFFF_FFFF, 1'b1, 32'h0000_0001};
      tbl[3] = '{32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF};
      tbl[4] = '{32'h0000_0000, 1'b0, 32'h0000_0000};
      tbl[5] = '{32'h0000_0001, 1'b0, 32'h0000_0001};
      tbl[6] = '{32'hFFFF_FFFE, 1'b1, 32'h0000_0002};
      tbl[7] = '{32'h1234_5678, 1'b0, 32'h1234_5678};
      tbl[8] = '{32'hEDCB_A988, 1'b1, 32'h1234_5678};
      tbl[9] = '{32'hC000_0001, 1'b1, 32'h3FFF_FFFF};

      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sign", out_sign, 0);
      chk("rst_out_mag", out_mag, 0);
      chk("rst_busy", busy, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run_word(tbl[i].d, i % 3, s, m, lat);
         chk("tbl_sign", s, tbl[i].s);
         chk("tbl_mag", m, tbl[i].m);
         chk("tbl_lat", lat, exp_lat(tbl[i].d));
      end

      // Back-to-back with out_ready held high
      g0 = got_q.size();
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_data = 32'h2000_0000;
      n0 = acc_n;
      t = 0;
      while (acc_n == n0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      a1 = acc_cyc.size() > 0 ? acc_cyc[$] : 0;
      in_data = 32'h0000_0000;
      t = 0;
      while (acc_n == n0 + 1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      a2 = acc_cyc.size() > 0 ? acc_cyc[$] : 0;
      in_valid = 1'b0;
`ifdef TC_SM_EARLY_DONE_EN
      chk("b2b_gap", a2 - a1, 3);
`else
      chk("b2b_gap", a2 - a1, W + 2);
`endif
      t = 0;
      while (got_q.size() < g0 + 2 && t < 200) begin
         @(negedge clk);
         t++;
      end
      out_ready = 1'b0;
      chk("b2b_count", got_q.size(), g0 + 2);
      if (got_q.size() >= g0 + 2) begin
         chk("b2b_s0", got_q[g0].s, 0);
         chk("b2b_m0", got_q[g0].m, 32'h2000_0000);
         chk("b2b_s1", got_q[g0+1].s, 0);
         chk("b2b_m1", got_q[g0+1].m, 32'h0000_0000);
      end

      // Backpressure: 10 stalled cycles in DONE
      run_word(32'h0235_0000, 10, s, m, lat);
      chk("bp_sign", s, 0);
      chk("bp_mag", m, 32'h0235_0000);
      chk("bp_lat", lat, exp_lat(32'h0235_0000));

      // Reset in the middle of the serial walk
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 32'hFFFF_FD00;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (12) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_sign", out_sign, 0);
      chk("mid_rst_mag", out_mag, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      chk("no_valid_after_rst", pulses, 0);
      run_word(32'h0001_3000, 0, s, m, lat);
      chk("post_rst_sign", s, 0);
      chk("post_rst_mag", m, 32'h0001_3000);

      // Random words with random stalls
      for (int i = 0; i < 1000; i++) begin
         d = W'($urandom);
         case ($urandom_range(0, 9))
            0: d = 32'h8000_0000;
            1: d = 32'h0000_0000;
            2: d = d | 32'hFFFF_0000;
            3: d = d & 32'h0000_00FF;
            default: ;
         endcase
         run_word(d, int'($urandom_range(0, 3)), s, m, lat);
         r = ref_model(d);
         chk("rnd_sign", s, r.s);
         chk("rnd_mag", m, r.m);
         chk("rnd_lat", lat, exp_lat(d));
      end

      repeat (3) @(negedge clk);
      chk("sb_drain", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
